// File: rtl/debounce_fsm.sv
// -----------------------------------------------------------------------------
// debounce_fsm
//
// Tick-driven switch/button debouncer. The raw asynchronous input is passed
// through a SYNC_STAGES-deep synchroniser. A candidate change must then stay
// stable for STABLE_TICKS consecutive ticks before the clean level follows it.
// The tick normally comes from a 10 ms ticker. It may also be tied high, and
// then every clock counts as a tick.
//
// Optional feature (compile-time macro DEBOUNCE_PULSE_EN):
//   defined     : db_pulse is a registered 1-clk strobe. It is high in the
//                 cycle where db_level first reads 1 after a rising change.
//   not defined : db_pulse is tied to 0 and no logic is built for it.
//
// Parameters:
//   STABLE_TICKS  ticks of stable input needed to accept a change (>=1)
//   CNT_W         tick-counter width; 2**CNT_W must exceed STABLE_TICKS
//   SYNC_STAGES   synchroniser flop count on btn_in (>=2)
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   tick      in   1-clk enable pulse from the ticker
//   btn_in    in   raw, bouncing, asynchronous input
//   db_level  out  debounced level, registered
//   busy      out  high while a candidate change is being qualified
//   db_pulse  out  rising-edge strobe (see DEBOUNCE_PULSE_EN above)
// -----------------------------------------------------------------------------
module debounce_fsm #(
   parameter int STABLE_TICKS = 2,
   parameter int CNT_W        = 4,
   parameter int SYNC_STAGES  = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic btn_in,
   output logic db_level,
   output logic busy,
   output logic db_pulse
);

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      WAIT_HI = 2'd1,
      IDLE_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   // The counter value that completes a qualification on the next tick.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   btn_s;

`ifdef DEBOUNCE_PULSE_EN
   logic pulse_q;
`endif

   // -------------------------------------------------------------------------
   // Input synchroniser. btn_in is sampled into bit 0 and shifts toward the
   // MSB, so btn_s lags btn_in by SYNC_STAGES clocks.
   // -------------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments only.
   //       Each flop then samples the value its neighbour held before the
   //       edge, which is what makes this a shift chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
      end
   end

   assign btn_s = sync_q[SYNC_STAGES-1];

   // -------------------------------------------------------------------------
   // Debounce FSM. Each clock allows at most one transition. In a WAIT state,
   // a reversal of btn_s takes priority over a tick arriving in the same
   // clock. A candidate that reverses at the moment it would have completed
   // is therefore rejected.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE_LO;
         cnt      <= '0;
         db_level <= 1'b0;
`ifdef DEBOUNCE_PULSE_EN
         pulse_q  <= 1'b0;
`endif
      end else begin
`ifdef DEBOUNCE_PULSE_EN
         pulse_q <= 1'b0;
`endif
         case (state)
            IDLE_LO: begin
               if (btn_s) begin
                  state <= WAIT_HI;
                  cnt   <= '0;
               end
            end

            WAIT_HI: begin
               if (!btn_s) begin
                  state <= IDLE_LO;
                  cnt   <= '0;
               end else if (tick) begin
                  if (cnt == CNT_LAST) begin
                     state    <= IDLE_HI;
                     db_level <= 1'b1;
                     cnt      <= '0;
`ifdef DEBOUNCE_PULSE_EN
                     pulse_q  <= 1'b1;
`endif
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end

            IDLE_HI: begin
               if (!btn_s) begin
                  state <= WAIT_LO;
                  cnt   <= '0;
               end
            end

            WAIT_LO: begin
               if (btn_s) begin
                  state <= IDLE_HI;
                  cnt   <= '0;
               end else if (tick) begin
                  if (cnt == CNT_LAST) begin
                     state    <= IDLE_LO;
                     db_level <= 1'b0;
                     cnt      <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end

            default: begin
               state <= IDLE_LO;
               cnt   <= '0;
            end
         endcase
      end
   end

   // busy is decoded directly from the state register, so it is glitch-free
   // and changes on the same edge that db_level does.
   assign busy = (state == WAIT_HI) | (state == WAIT_LO);

`ifdef DEBOUNCE_PULSE_EN
   assign db_pulse = pulse_q;
`else
   assign db_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_fsm.sv
// -----------------------------------------------------------------------------
// tb_debounce_fsm
//
// Directed bench for debounce_fsm with STABLE_TICKS=2. Each test restarts the
// tick phase, so the tick lands on clock edges 4, 8, 12, ... of that test.
// Observed outputs are packed as {db_level, busy, db_pulse} and sampled 1 ns
// after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_debounce_fsm;

`ifdef DEBOUNCE_PULSE_EN
   localparam logic PEN = 1'b1;
`else
   localparam logic PEN = 1'b0;
`endif

   logic clk    = 1'b0;
   logic reset  = 1'b1;
   logic tick   = 1'b0;
   logic btn_in = 1'b0;
   logic db_level, busy, db_pulse;

   wire [2:0] obs = {db_level, busy, db_pulse};

   int vectors     = 0;
   int miscompares = 0;
   int phase       = 0;
   int pulses      = 0;

   debounce_fsm #(
      .STABLE_TICKS (2),
      .CNT_W        (4),
      .SYNC_STAGES  (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .btn_in   (btn_in),
      .db_level (db_level),
      .busy     (busy),
      .db_pulse (db_pulse)
   );

   always #5 clk = ~clk;

   // Advance n clocks. The tick is high on every 4th edge of the current phase.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         tick = (phase == 3);
         @(posedge clk);
         #1;
         phase = (phase + 1) % 4;
         if (db_pulse === 1'b1) pulses++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         btn_in = i[0];
         @(posedge clk);
         #1;
         vectors++;
         if (obs !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_hold[%0d]: got %b want %b", i, obs, 3'b000);
         end
      end
      btn_in = 1'b0;
      tick   = 1'b0;
      reset  = 1'b0;
      phase  = 0;
      run(4);
      vectors++;
      if (obs !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_release: got %b want %b", obs, 3'b000);
      end
   endtask

   // The input goes high for 3 clocks, then low. The FSM enters WAIT_HI and
   // takes one tick, but it returns to IDLE_LO before any second tick.
   task automatic test_bounce;
      phase  = 0;
      pulses = 0;
      btn_in = 1'b1;
      run(3);
      vectors++;
      if (obs !== 3'b010) begin
         miscompares++;
         $display("FAIL bounce_enter: got %b want %b", obs, 3'b010);
      end
      btn_in = 1'b0;
      run(2);
      vectors++;
      if (obs !== 3'b010) begin
         miscompares++;
         $display("FAIL bounce_wait: got %b want %b", obs, 3'b010);
      end
      run(1);
      vectors++;
      if (obs !== 3'b000) begin
         miscompares++;
         $display("FAIL bounce_abort: got %b want %b", obs, 3'b000);
      end
      run(6);
      vectors++;
      if (obs !== 3'b000) begin
         miscompares++;
         $display("FAIL bounce_settled: got %b want %b", obs, 3'b000);
      end
      vectors++;
      if (pulses !== 0) begin
         miscompares++;
         $display("FAIL bounce_pulses: got %0d want %0d", pulses, 0);
      end
   endtask

   // Clean 0->1 edge held for 20 clocks. busy rises after edge 3. The tick on
   // edge 4 counts 0->1, and the tick on edge 8 completes the change.
   task automatic test_rise;
      phase  = 0;
      pulses = 0;
      btn_in = 1'b1;
      run(2);
      vectors++;
      if (obs !== 3'b000) begin
         miscompares++;
         $display("FAIL rise_sync: got %b want %b", obs, 3'b000);
      end
      run(1);
      vectors++;
      if (obs !== 3'b010) begin
         miscompares++;
         $display("FAIL rise_busy: got %b want %b", obs, 3'b010);
      end
      run(4);
      vectors++;
      if (obs !== 3'b010) begin
         miscompares++;
         $display("FAIL rise_wait: got %b want %b", obs, 3'b010);
      end
      run(1);
      vectors++;
      if (obs !== {1'b1, 1'b0, PEN}) begin
         miscompares++;
         $display("FAIL rise_done: got %b want %b", obs, {1'b1, 1'b0, PEN});
      end
      run(1);
      vectors++;
      if (obs !== 3'b100) begin
         miscompares++;
         $display("FAIL rise_pulse_end: got %b want %b", obs, 3'b100);
      end
      run(11);
      vectors++;
      if (obs !== 3'b100) begin
         miscompares++;
         $display("FAIL rise_hold: got %b want %b", obs, 3'b100);
      end
      vectors++;
      if (pulses !== (PEN ? 1 : 0)) begin
         miscompares++;
         $display("FAIL rise_pulses: got %0d want %0d", pulses, (PEN ? 1 : 0));
      end
   endtask

   // Mirror of the rising case, starting from db_level=1. No strobe is
   // expected on a falling change.
   task automatic test_fall;
      phase  = 0;
      pulses = 0;
      btn_in = 1'b0;
      run(2);
      vectors++;
      if (obs !== 3'b100) begin
         miscompares++;
         $display("FAIL fall_sync: got %b want %b", obs, 3'b100);
      end
      run(1);
      vectors++;
      if (obs !== 3'b110) begin
         miscompares++;
         $display("FAIL fall_busy: got %b want %b", obs, 3'b110);
      end
      run(4);
      vectors++;
      if (obs !== 3'b110) begin
         miscompares++;
         $display("FAIL fall_wait: got %b want %b", obs, 3'b110);
      end
      run(1);
      vectors++;
      if (obs !== 3'b000) begin
         miscompares++;
         $display("FAIL fall_done: got %b want %b", obs, 3'b000);
      end
      vectors++;
      if (pulses !== 0) begin
         miscompares++;
         $display("FAIL fall_pulses: got %0d want %0d", pulses, 0);
      end
   endtask

   // btn_in is low from edge 6, so btn_s drops after edge 7. That drop
   // coincides with the completing tick on edge 8, and the bounce must win.
   task automatic test_tick_race;
      phase  = 0;
      pulses = 0;
      btn_in = 1'b1;
      run(5);
      btn_in = 1'b0;
      run(2);
      vectors++;
      if (obs !== 3'b010) begin
         miscompares++;
         $display("FAIL race_wait: got %b want %b", obs, 3'b010);
      end
      run(1);
      vectors++;
      if (obs !== 3'b000) begin
         miscompares++;
         $display("FAIL race_reject: got %b want %b", obs, 3'b000);
      end
      run(4);
      vectors++;
      if (obs !== 3'b000) begin
         miscompares++;
         $display("FAIL race_settled: got %b want %b", obs, 3'b000);
      end
      vectors++;
      if (pulses !== 0) begin
         miscompares++;
         $display("FAIL race_pulses: got %0d want %0d", pulses, 0);
      end
   endtask

   // Reset is asserted while in WAIT_HI with cnt=1. After release, the input
   // must requalify from scratch: 3 clocks of sync/entry, then two ticks.
   task automatic test_reset_mid_wait;
      phase  = 0;
      pulses = 0;
      btn_in = 1'b1;
      run(5);
      vectors++;
      if (obs !== 3'b010) begin
         miscompares++;
         $display("FAIL rmw_busy: got %b want %b", obs, 3'b010);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (obs !== 3'b000) begin
         miscompares++;
         $display("FAIL rmw_async: got %b want %b", obs, 3'b000);
      end
      run(2);
      vectors++;
      if (obs !== 3'b000) begin
         miscompares++;
         $display("FAIL rmw_held: got %b want %b", obs, 3'b000);
      end
      reset = 1'b0;
      phase = 0;
      run(7);
      vectors++;
      if (obs !== 3'b010) begin
         miscompares++;
         $display("FAIL rmw_requalify: got %b want %b", obs, 3'b010);
      end
      run(1);
      vectors++;
      if (obs !== {1'b1, 1'b0, PEN}) begin
         miscompares++;
         $display("FAIL rmw_done: got %b want %b", obs, {1'b1, 1'b0, PEN});
      end
      vectors++;
      if (pulses !== (PEN ? 1 : 0)) begin
         miscompares++;
         $display("FAIL rmw_pulses: got %0d want %0d", pulses, (PEN ? 1 : 0));
      end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_rise();
      test_fall();
      test_tick_race();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
